// File: rtl/mux_pkg.sv
// Shared definitions for the pipelined N:1 multiplexer: size limits, the per-stage
// control bundle and the select range check.
package mux_pkg;

  localparam int unsigned MUX_MAX_N   = 64;
  localparam int unsigned MUX_MAX_LAT = 4;
  localparam int unsigned MUX_MAX_SW  = $clog2(MUX_MAX_N);

  // Control fields of one pipeline stage. The select is held at its widest legal size;
  // each stage masks it down to the configured select width.
  typedef struct packed {
    logic                  valid;
    logic [MUX_MAX_SW-1:0] sel;
    logic                  err;
  } mux_stage_t;

  function automatic logic sel_in_range(input logic [31:0] sel, input int unsigned n);
    return sel < n;
  endfunction

endpackage

// File: rtl/mux_pipe_stage.sv
// One register stage of the multiplexer pipeline. Holds {valid, sel, err} plus a data
// word; loads from upstream when enabled, otherwise holds everything unchanged.
module mux_pipe_stage
  import mux_pkg::*;
#(
  parameter int unsigned W  = 32,
  parameter int unsigned SW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  mux_stage_t   i_ctrl,
  input  logic [W-1:0] i_data,
  output mux_stage_t   o_ctrl,
  output logic [W-1:0] o_data
);

  localparam logic [MUX_MAX_SW-1:0] SelMask = {MUX_MAX_SW{1'b1}} >> (MUX_MAX_SW - SW);

  mux_stage_t   r_ctrl;
  logic [W-1:0] r_data;

  // Bubbles only move the valid bit, so an idle stage keeps its last word (zero after reset).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrl <= '0;
      r_data <= '0;
    end else if (i_en) begin
      r_ctrl.valid <= i_ctrl.valid;
      if (i_ctrl.valid) begin
        r_ctrl.sel <= i_ctrl.sel & SelMask;
        r_ctrl.err <= i_ctrl.err;
        r_data     <= i_data;
      end
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_data = r_data;

endmodule

// File: rtl/pipelined_mux_nto1.sv
// N-input, W-bit selector followed by LAT registered stages with valid/ready flow control.
// Selects >= N produce a zero word with out_err set.
// Optional build macro MUX_PARITY_EN adds out_par, the XOR reduction of the selected word,
// computed at stage 0 and carried alongside the data through every stage.
module pipelined_mux_nto1
  import mux_pkg::*;
#(
  parameter int unsigned W   = 32,
  parameter int unsigned N   = 16,
  parameter int unsigned LAT = 1,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [SW-1:0]  in_sel,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  output logic           out_err,
`ifdef MUX_PARITY_EN
  output logic           out_par,
`endif
  output logic           out_valid,
  input  logic           out_ready
);

`ifdef MUX_PARITY_EN
  localparam int unsigned DW = W + 1;
`else
  localparam int unsigned DW = W;
`endif

  if (N < 2 || N > MUX_MAX_N) begin : g_bad_n
    $error("pipelined_mux_nto1: N must be within 2..%0d", MUX_MAX_N);
  end
  if (LAT < 1 || LAT > MUX_MAX_LAT) begin : g_bad_lat
    $error("pipelined_mux_nto1: LAT must be within 1..%0d", MUX_MAX_LAT);
  end

  logic             w_in_range;
  logic [31:0]      w_lsb;
  logic [W-1:0]     w_sel_data;
  logic [DW-1:0]    w_load_data;
  mux_stage_t       w_load_ctrl;
  logic [LAT:0]     w_en;
  mux_stage_t       w_ctrl [LAT];
  logic [DW-1:0]    w_data [LAT];
  logic             w_unused_sel;

  assign w_in_range = sel_in_range(32'(in_sel), N);
  assign w_lsb      = 32'(in_sel) * W;
  assign w_sel_data = w_in_range ? in_data[w_lsb +: W] : '0;

`ifdef MUX_PARITY_EN
  assign w_load_data = {^w_sel_data, w_sel_data};
`else
  assign w_load_data = w_sel_data;
`endif

  // Stage 0 load bundle; valid follows in_valid because stage 0 only loads when in_ready.
  always_comb begin
    w_load_ctrl       = '0;
    w_load_ctrl.valid = in_valid;
    w_load_ctrl.sel   = MUX_MAX_SW'(in_sel);
    w_load_ctrl.err   = !w_in_range;
  end

  // A stage may advance when it or any stage downstream is empty, or the consumer takes a word.
  always_comb begin
    w_en      = '0;
    w_en[LAT] = out_ready;
    for (int i = int'(LAT) - 1; i >= 0; i--) begin
      w_en[i] = w_en[i+1] || !w_ctrl[i].valid;
    end
  end

  for (genvar i = 0; i < LAT; i++) begin : g_stage
    mux_stage_t    w_stg_ctrl;
    logic [DW-1:0] w_stg_data;

    if (i == 0) begin : g_first
      assign w_stg_ctrl = w_load_ctrl;
      assign w_stg_data = w_load_data;
    end else begin : g_next
      assign w_stg_ctrl = w_ctrl[i-1];
      assign w_stg_data = w_data[i-1];
    end

    mux_pipe_stage #(
      .W (DW),
      .SW(SW)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_en[i]),
      .i_ctrl(w_stg_ctrl),
      .i_data(w_stg_data),
      .o_ctrl(w_ctrl[i]),
      .o_data(w_data[i])
    );
  end

  assign in_ready  = w_en[0];
  assign out_valid = w_ctrl[LAT-1].valid;
  assign out_sel   = w_ctrl[LAT-1].sel[SW-1:0];
  assign out_err   = w_ctrl[LAT-1].err;
  assign out_data  = w_data[LAT-1][W-1:0];
`ifdef MUX_PARITY_EN
  assign out_par   = w_data[LAT-1][W];
`endif

  // Upper select bits are always zero after masking in the stages.
  assign w_unused_sel = ^w_ctrl[LAT-1].sel;

endmodule

// File: tb/tb_pipelined_mux_nto1.sv
// Bench for pipelined_mux_nto1: three instances (N16/LAT1, N16/LAT3, N10/LAT2) driven by
// directed scenarios and a randomized run checked against a queue-based reference model.
module tb_pipelined_mux_nto1;

  localparam int unsigned NS [3] = '{16, 16, 10};
  localparam int unsigned LS [3] = '{1, 3, 2};

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  sel;
    logic        err;
    logic        par;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [511:0] in_data   [3];
  logic [3:0]   in_sel    [3];
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [31:0]  out_data  [3];
  logic [3:0]   out_sel   [3];
  logic         out_err   [3];
`ifdef MUX_PARITY_EN
  logic         out_par   [3];
`endif
  logic         out_valid [3];
  logic         out_ready [3];

  int n_checks = 0;
  int n_pass   = 0;
  exp_t q [3][$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipelined_mux_nto1 #(
      .W  (32),
      .N  (NS[g]),
      .LAT(LS[g])
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data[g][NS[g]*32-1:0]),
      .in_sel   (in_sel[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .out_data (out_data[g]),
      .out_sel  (out_sel[g]),
      .out_err  (out_err[g]),
`ifdef MUX_PARITY_EN
      .out_par  (out_par[g]),
`endif
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // Expected output word from the selection rule alone.
  function automatic exp_t model_word(input int d, input logic [511:0] data,
                                      input logic [3:0] sel);
    exp_t e;
    e = '0;
    e.sel = sel;
    if (int'(sel) < int'(NS[d])) e.data = data[int'(sel)*32 +: 32];
    else e.err = 1'b1;
    e.par = ^e.data;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b0;
      in_sel[d] = '0;
      in_data[d] = '0;
      q[d].delete();
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b1;
      in_sel[d] = 4'(d + 1);
      in_data[d] = {16{32'h1234_5678}};
      out_ready[d] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (out_valid[d] !== 1'b0) $display("FAIL reset_valid[%0d]: got %b want 0", d, out_valid[d]);
      else n_pass++;
      n_checks++;
      if (out_data[d] !== 32'h0) $display("FAIL reset_data[%0d]: got %h want 0", d, out_data[d]);
      else n_pass++;
      n_checks++;
      if ({out_sel[d], out_err[d]} !== 5'h0)
        $display("FAIL reset_sel_err[%0d]: got %h/%b want 0/0", d, out_sel[d], out_err[d]);
      else n_pass++;
      n_checks++;
      if (in_ready[d] !== 1'b1) $display("FAIL reset_ready[%0d]: got %b want 1", d, in_ready[d]);
      else n_pass++;
`ifdef MUX_PARITY_EN
      n_checks++;
      if (out_par[d] !== 1'b0) $display("FAIL reset_par[%0d]: got %b want 0", d, out_par[d]);
      else n_pass++;
`endif
    end
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) in_valid[d] = 1'b0;
    in_data[0][5*32 +: 32] = 32'hDEAD_BEEF;
    in_sel[0] = 4'd5;
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    #1;
    n_checks++;
    if ({out_valid[0], out_data[0], out_sel[0], out_err[0]} !== {1'b1, 32'hDEAD_BEEF, 4'd5, 1'b0})
      $display("FAIL first_word: got v=%b d=%h s=%0d e=%b want v=1 d=deadbeef s=5 e=0",
               out_valid[0], out_data[0], out_sel[0], out_err[0]);
    else n_pass++;
  endtask

  task automatic test_streaming();
    logic exp_v;
    do_reset();
    out_ready[1] = 1'b1;
    for (int k = 0; k < 16; k++) in_data[1][k*32 +: 32] = 32'h1000 + k;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      in_valid[1] = (c < 16);
      in_sel[1] = 4'(c);
      #1;
      exp_v = (c >= 3) && (c <= 18);
      n_checks++;
      if (in_ready[1] !== 1'b1) $display("FAIL stream_ready c=%0d: got %b want 1", c, in_ready[1]);
      else n_pass++;
      n_checks++;
      if (out_valid[1] !== exp_v)
        $display("FAIL stream_valid c=%0d: got %b want %b", c, out_valid[1], exp_v);
      else n_pass++;
      if (exp_v) begin
        n_checks++;
        if ({out_data[1], out_sel[1]} !== {32'h1000 + 32'(c - 3), 4'(c - 3)})
          $display("FAIL stream_data c=%0d: got %h/%0d want %h/%0d", c, out_data[1], out_sel[1],
                   32'h1000 + 32'(c - 3), c - 3);
        else n_pass++;
      end
    end
    in_valid[1] = 1'b0;
  endtask

  task automatic test_backpressure();
    int sent;
    int got;
    logic exp_ready;
    do_reset();
    sent = 0;
    got = 0;
    for (int k = 0; k < 16; k++) in_data[2][k*32 +: 32] = 32'h2000 + k;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      out_ready[2] = (c >= 6);
      in_valid[2] = (sent < 4);
      in_sel[2] = 4'(sent);
      #1;
      exp_ready = ((sent - got) < 2) || out_ready[2];
      n_checks++;
      if (in_ready[2] !== exp_ready)
        $display("FAIL bp_ready c=%0d: got %b want %b", c, in_ready[2], exp_ready);
      else n_pass++;
      if (c >= 2 && c < 6) begin
        n_checks++;
        if ({out_valid[2], out_data[2]} !== {1'b1, 32'h2000})
          $display("FAIL bp_hold c=%0d: got v=%b d=%h want v=1 d=2000", c, out_valid[2],
                   out_data[2]);
        else n_pass++;
      end
      if (out_valid[2] && out_ready[2]) begin
        n_checks++;
        if (out_data[2] !== 32'h2000 + 32'(got))
          $display("FAIL bp_order: got %h want %h", out_data[2], 32'h2000 + 32'(got));
        else n_pass++;
        got++;
      end
      if (in_valid[2] && exp_ready) sent++;
    end
    n_checks++;
    if (got !== 4) $display("FAIL bp_count: got %0d words want 4", got);
    else n_pass++;
    n_checks++;
    if (out_valid[2] !== 1'b0) $display("FAIL bp_empty: got valid %b want 0", out_valid[2]);
    else n_pass++;
    in_valid[2] = 1'b0;
  endtask

  task automatic test_out_of_range();
    do_reset();
    for (int k = 0; k < 16; k++) in_data[2][k*32 +: 32] = $urandom;
    in_data[2][9*32 +: 32] = 32'hA5;
    in_data[2][12*32 +: 32] = 32'hFFFF_FFFF;
    in_data[0][15*32 +: 32] = 32'h0F0F;
    out_ready[0] = 1'b1;
    out_ready[2] = 1'b1;
    @(negedge clk);
    in_valid[2] = 1'b1;
    in_sel[2] = 4'd12;
    in_valid[0] = 1'b1;
    in_sel[0] = 4'd15;
    @(negedge clk);
    in_sel[2] = 4'd9;
    in_valid[0] = 1'b0;
    #1;
    n_checks++;
    if ({out_valid[0], out_data[0], out_sel[0], out_err[0]} !== {1'b1, 32'h0F0F, 4'd15, 1'b0})
      $display("FAIL pow2_no_err: got v=%b d=%h s=%0d e=%b want v=1 d=f0f s=15 e=0",
               out_valid[0], out_data[0], out_sel[0], out_err[0]);
    else n_pass++;
    @(negedge clk);
    in_valid[2] = 1'b0;
    #1;
    n_checks++;
    if ({out_valid[2], out_data[2], out_sel[2], out_err[2]} !== {1'b1, 32'h0, 4'd12, 1'b1})
      $display("FAIL oor_word: got v=%b d=%h s=%0d e=%b want v=1 d=0 s=12 e=1",
               out_valid[2], out_data[2], out_sel[2], out_err[2]);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if ({out_valid[2], out_data[2], out_sel[2], out_err[2]} !== {1'b1, 32'hA5, 4'd9, 1'b0})
      $display("FAIL in_range_after_oor: got v=%b d=%h s=%0d e=%b want v=1 d=a5 s=9 e=0",
               out_valid[2], out_data[2], out_sel[2], out_err[2]);
    else n_pass++;
  endtask

  task automatic test_full_simultaneous();
    do_reset();
    for (int k = 0; k < 16; k++) in_data[0][k*32 +: 32] = 32'h3000 + k;
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_sel[0] = 4'd1;
    #1;
    n_checks++;
    if (in_ready[0] !== 1'b1) $display("FAIL full_first_ready: got %b want 1", in_ready[0]);
    else n_pass++;
    @(negedge clk);
    in_sel[0] = 4'd2;
    #1;
    n_checks++;
    if ({out_valid[0], out_data[0], in_ready[0]} !== {1'b1, 32'h3001, 1'b0})
      $display("FAIL full_stall: got v=%b d=%h rdy=%b want v=1 d=3001 rdy=0", out_valid[0],
               out_data[0], in_ready[0]);
    else n_pass++;
    @(negedge clk);
    in_sel[0] = 4'd3;
    out_ready[0] = 1'b1;
    #1;
    n_checks++;
    if ({in_ready[0], out_data[0]} !== {1'b1, 32'h3001})
      $display("FAIL full_simul_ready: got rdy=%b d=%h want rdy=1 d=3001", in_ready[0],
               out_data[0]);
    else n_pass++;
    @(negedge clk);
    in_valid[0] = 1'b0;
    #1;
    n_checks++;
    if ({out_valid[0], out_data[0], out_sel[0]} !== {1'b1, 32'h3003, 4'd3})
      $display("FAIL full_no_bubble: got v=%b d=%h s=%0d want v=1 d=3003 s=3", out_valid[0],
               out_data[0], out_sel[0]);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid[0] !== 1'b0) $display("FAIL full_drained: got %b want 0", out_valid[0]);
    else n_pass++;

    // Reset with two words in flight through the LAT=3 instance.
    out_ready[1] = 1'b1;
    for (int k = 0; k < 16; k++) in_data[1][k*32 +: 32] = 32'h4000 + k;
    @(negedge clk);
    in_valid[1] = 1'b1;
    in_sel[1] = 4'd4;
    @(negedge clk);
    in_sel[1] = 4'd5;
    @(negedge clk);
    in_valid[1] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid[1] !== 1'b0) $display("FAIL midreset_valid: got %b want 0", out_valid[1]);
    else n_pass++;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (out_valid[1] !== 1'b0)
        $display("FAIL midreset_stale c=%0d: got valid %b data %h want valid 0", c,
                 out_valid[1], out_data[1]);
      else n_pass++;
    end
  endtask

`ifdef MUX_PARITY_EN
  task automatic test_parity();
    logic [31:0] exp_d [3];
    logic        exp_p [3];
    int got;
    exp_d = '{32'h7, 32'h3, 32'h1};
    exp_p = '{1'b1, 1'b0, 1'b1};
    got = 0;
    do_reset();
    for (int k = 0; k < 3; k++) in_data[1][k*32 +: 32] = exp_d[k];
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      in_valid[1] = (c < 3);
      in_sel[1] = 4'(c);
      out_ready[1] = (c >= 6);
      #1;
      if (c >= 3 && c < 6) begin
        n_checks++;
        if ({out_valid[1], out_data[1], out_par[1]} !== {1'b1, 32'h7, 1'b1})
          $display("FAIL par_stall c=%0d: got v=%b d=%h p=%b want v=1 d=7 p=1", c,
                   out_valid[1], out_data[1], out_par[1]);
        else n_pass++;
      end
      if (out_valid[1] && out_ready[1] && got < 3) begin
        n_checks++;
        if ({out_data[1], out_par[1]} !== {exp_d[got], exp_p[got]})
          $display("FAIL par_word%0d: got d=%h p=%b want d=%h p=%b", got, out_data[1],
                   out_par[1], exp_d[got], exp_p[got]);
        else n_pass++;
        got++;
      end
    end
    n_checks++;
    if (got !== 3) $display("FAIL par_count: got %0d want 3", got);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    logic exp_ready;
    logic acc [3];
    logic pop [3];
    exp_t accw [3];
    exp_t h;
    do_reset();
    for (int c = 0; c < 412; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (c < 400) begin
          in_valid[d] = ($urandom_range(0, 9) < 7);
          in_sel[d] = 4'($urandom_range(0, 15));
          for (int k = 0; k < 16; k++) in_data[d][k*32 +: 32] = $urandom;
          out_ready[d] = ($urandom_range(0, 9) < 6);
        end else begin
          in_valid[d] = 1'b0;
          out_ready[d] = 1'b1;
        end
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        exp_ready = (q[d].size() < int'(LS[d])) || out_ready[d];
        n_checks++;
        if (in_ready[d] !== exp_ready)
          $display("FAIL rnd_ready[%0d] c=%0d: got %b want %b", d, c, in_ready[d], exp_ready);
        else n_pass++;
        if (q[d].size() == 0) begin
          n_checks++;
          if (out_valid[d] !== 1'b0)
            $display("FAIL rnd_empty[%0d] c=%0d: got valid %b want 0", d, c, out_valid[d]);
          else n_pass++;
        end else if (q[d].size() == int'(LS[d])) begin
          n_checks++;
          if (out_valid[d] !== 1'b1)
            $display("FAIL rnd_full[%0d] c=%0d: got valid %b want 1", d, c, out_valid[d]);
          else n_pass++;
        end
        if (out_valid[d] === 1'b1 && q[d].size() > 0) begin
          h = q[d][0];
          n_checks++;
`ifdef MUX_PARITY_EN
          if ({out_data[d], out_sel[d], out_err[d], out_par[d]} !== {h.data, h.sel, h.err, h.par})
            $display("FAIL rnd_word[%0d] c=%0d: got %h/%0d/%b/%b want %h/%0d/%b/%b", d, c,
                     out_data[d], out_sel[d], out_err[d], out_par[d], h.data, h.sel, h.err,
                     h.par);
`else
          if ({out_data[d], out_sel[d], out_err[d]} !== {h.data, h.sel, h.err})
            $display("FAIL rnd_word[%0d] c=%0d: got %h/%0d/%b want %h/%0d/%b", d, c,
                     out_data[d], out_sel[d], out_err[d], h.data, h.sel, h.err);
`endif
          else n_pass++;
        end
        pop[d] = out_valid[d] && out_ready[d] && (q[d].size() > 0);
        acc[d] = in_valid[d] && exp_ready;
        accw[d] = model_word(d, in_data[d], in_sel[d]);
      end
      @(posedge clk);
      for (int d = 0; d < 3; d++) begin
        if (pop[d]) void'(q[d].pop_front());
        if (acc[d]) q[d].push_back(accw[d]);
      end
    end
    @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (q[d].size() != 0 || out_valid[d] !== 1'b0)
        $display("FAIL rnd_drain[%0d]: got %0d pending, valid %b want 0 pending, valid 0", d,
                 q[d].size(), out_valid[d]);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_data[d] = '0;
      in_sel[d] = '0;
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b0;
    end
    test_reset();
    test_streaming();
    test_backpressure();
    test_out_of_range();
    test_full_simultaneous();
`ifdef MUX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
